pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its flush consumers.
// Holds the controller state encoding, the NOP bubble word and the opcode defines.
package pipeline_hazard_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } hz_state_e;

    // Bubble inserted by a flushed IF/ID or ID/EX register (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubble flushes, branch PC select
// and a sticky data-memory timeout fault for a 5-stage in-order pipeline.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load_use_stall      load-use hazard request
//   i_branch_taken        taken branch/jump resolved in EX
//   i_imem_ready          fetch data valid this cycle
//   i_dmem_req            MEM-stage load/store active
//   i_dmem_ready          MEM-stage access completes this cycle
//   o_*_en                PC and pipeline register enables
//   o_if_id_flush         load NOP bubble into IF/ID
//   o_id_ex_flush         load NOP bubble into ID/EX
//   o_pc_sel_branch       PC takes branch target
//   o_mem_fault           sticky data-memory timeout
//   o_stall_cnt           (HAZARD_PERF_CNT_EN) saturating PC-stall cycle count
//   o_flush_cnt           (HAZARD_PERF_CNT_EN) saturating branch-flush count
//
// Build option: define HAZARD_PERF_CNT_EN to add the performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_use_stall,
    input  logic        i_branch_taken,
    input  logic        i_imem_ready,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_pc_sel_branch,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt,
`endif
    output logic        o_mem_fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_prio;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        run_prio        = 1'b0;
        o_pc_en         = 1'b0;
        o_if_id_en      = 1'b0;
        o_id_ex_en      = 1'b0;
        o_ex_mem_en     = 1'b0;
        o_mem_wb_en     = 1'b0;
        o_if_id_flush   = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_pc_sel_branch = 1'b0;
        o_mem_fault     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (i_dmem_req && !i_dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    run_prio = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!i_dmem_ready) begin
                    // cnt_q < MEM_TIMEOUT here, so the increment cannot wrap
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    // Access completes: the rest of the pipeline acts this cycle
                    run_prio = 1'b1;
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                end
            end
            ST_FAULT: begin
                o_mem_fault = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (run_prio) begin
            o_pc_en     = 1'b1;
            o_if_id_en  = 1'b1;
            o_id_ex_en  = 1'b1;
            o_ex_mem_en = 1'b1;
            o_mem_wb_en = 1'b1;
            if (i_branch_taken) begin
                o_pc_sel_branch = 1'b1;
                o_if_id_flush   = 1'b1;
                o_id_ex_flush   = 1'b1;
            end else if (i_load_use_stall) begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
            end else if (!i_imem_ready) begin
                // IF/ID stays enabled so it captures the bubble
                o_pc_en       = 1'b0;
                o_if_id_flush = 1'b1;
            end
        end

        // Hold everything and fill with bubbles while reset is asserted
        if (i_rst) begin
            o_pc_en         = 1'b0;
            o_if_id_en      = 1'b0;
            o_id_ex_en      = 1'b0;
            o_ex_mem_en     = 1'b0;
            o_mem_wb_en     = 1'b0;
            o_if_id_flush   = 1'b1;
            o_id_ex_flush   = 1'b1;
            o_pc_sel_branch = 1'b0;
            o_mem_fault     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!o_pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (o_pc_sel_branch && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Outputs are packed {pc,ifid,idex,exmem,memwb,ififl,idexfl,br,fault}.
module tb_pipeline_hazard_ctrl;

    logic i_clk = 1'b0;
    logic i_rst, i_lu, i_br, i_imem_rdy, i_dreq, i_drdy;
    logic o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
    logic o_if_id_flush, o_id_ex_flush, o_pc_sel_branch, o_mem_fault;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] o_stall_cnt;
    logic [15:0] o_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [8:0] E_NORM  = 9'b11111_00_0_0;
    localparam logic [8:0] E_MEMST = 9'b00000_00_0_0;
    localparam logic [8:0] E_BR    = 9'b11111_11_1_0;
    localparam logic [8:0] E_LU    = 9'b00111_01_0_0;
    localparam logic [8:0] E_FB    = 9'b01111_10_0_0;
    localparam logic [8:0] E_FAULT = 9'b00000_00_0_1;
    localparam logic [8:0] E_RST   = 9'b00000_11_0_0;

    wire [8:0] outs = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en,
                       o_mem_wb_en, o_if_id_flush, o_id_ex_flush,
                       o_pc_sel_branch, o_mem_fault};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_load_use_stall(i_lu),
        .i_branch_taken  (i_br),
        .i_imem_ready    (i_imem_rdy),
        .i_dmem_req      (i_dreq),
        .i_dmem_ready    (i_drdy),
        .o_pc_en         (o_pc_en),
        .o_if_id_en      (o_if_id_en),
        .o_id_ex_en      (o_id_ex_en),
        .o_ex_mem_en     (o_ex_mem_en),
        .o_mem_wb_en     (o_mem_wb_en),
        .o_if_id_flush   (o_if_id_flush),
        .o_id_ex_flush   (o_id_ex_flush),
        .o_pc_sel_branch (o_pc_sel_branch),
`ifdef HAZARD_PERF_CNT_EN
        .o_stall_cnt     (o_stall_cnt),
        .o_flush_cnt     (o_flush_cnt),
`endif
        .o_mem_fault     (o_mem_fault)
    );

    always #5 i_clk = ~i_clk;

    // Inputs {rst, lu, br, imem_rdy, dreq, drdy}
    task automatic drive(input logic [5:0] v);
        {i_rst, i_lu, i_br, i_imem_rdy, i_dreq, i_drdy} = v;
        #1;
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] v [3] = '{6'b101001, 6'b111111, 6'b100110};
        for (int i = 0; i < 3; i++) begin
            drive(v[i]);
            total++;
            if (outs !== E_RST) begin
                bad++;
                $display("FAIL reset[%0d] got=%b want=%b", i, outs, E_RST);
            end
            adv();
        end
        drive(6'b000100);
        total++;
        if (outs !== E_NORM) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", outs, E_NORM);
        end
        adv();
    endtask

    task automatic test_load_use();
        logic [5:0] v [3] = '{6'b010100, 6'b000100, 6'b010000};
        logic [8:0] e [3] = '{E_LU, E_NORM, E_LU};
        for (int i = 0; i < 3; i++) begin
            drive(v[i]);
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL load_use[%0d] got=%b want=%b", i, outs, e[i]);
            end
            adv();
        end
    endtask

    task automatic test_priority();
        // br+lu, br+fetch, lu+fetch, req&ready (no wait), fetch only
        logic [5:0] v [5] = '{6'b011100, 6'b001000, 6'b010000,
                              6'b000111, 6'b000000};
        logic [8:0] e [5] = '{E_BR, E_BR, E_LU, E_NORM, E_FB};
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL priority[%0d] got=%b want=%b", i, outs, e[i]);
            end
            adv();
        end
    endtask

    task automatic test_mem_wait();
        // 3 wait cycles then ready, then a second wait with held branch
        logic [5:0] v [8] = '{6'b000110, 6'b000110, 6'b000110, 6'b000111,
                              6'b000100, 6'b001110, 6'b001111, 6'b000100};
        logic [8:0] e [8] = '{E_MEMST, E_MEMST, E_MEMST, E_NORM,
                              E_NORM, E_MEMST, E_BR, E_NORM};
        for (int i = 0; i < 8; i++) begin
            drive(v[i]);
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL mem_wait[%0d] got=%b want=%b", i, outs, e[i]);
            end
            adv();
        end
    endtask

    task automatic test_timeout();
        logic [5:0] v [9] = '{6'b000110, 6'b000110, 6'b000110, 6'b000110,
                              6'b000110, 6'b000111, 6'b011100, 6'b100100,
                              6'b000100};
        logic [8:0] e [9] = '{E_MEMST, E_MEMST, E_MEMST, E_MEMST,
                              E_FAULT, E_FAULT, E_FAULT, E_RST, E_NORM};
        for (int i = 0; i < 9; i++) begin
            drive(v[i]);
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL timeout[%0d] got=%b want=%b", i, outs, e[i]);
            end
            adv();
        end
    endtask

    task automatic test_fetch_bubble();
        logic [5:0] v [5] = '{6'b100100, 6'b000100, 6'b000000,
                              6'b000000, 6'b001100};
        logic [8:0] e [5] = '{E_RST, E_NORM, E_FB, E_FB, E_BR};
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL fetch[%0d] got=%b want=%b", i, outs, e[i]);
            end
            adv();
        end
`ifdef HAZARD_PERF_CNT_EN
        drive(6'b000100);
        total++;
        if (o_stall_cnt !== 32'd2) begin
            bad++;
            $display("FAIL stall_cnt got=%0d want=2", o_stall_cnt);
        end
        total++;
        if (o_flush_cnt !== 16'd1) begin
            bad++;
            $display("FAIL flush_cnt got=%0d want=1", o_flush_cnt);
        end
        adv();
`endif
    endtask

    initial begin
        {i_rst, i_lu, i_br, i_imem_rdy, i_dreq, i_drdy} = 6'b100100;
        adv();
        test_reset();
        test_load_use();
        test_priority();
        test_mem_wait();
        test_timeout();
        test_fetch_bubble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
